seq_ram_writer: RTL

- Writer-side counterpart of the sequential ROM/RAM reader.
- Accepts a valid/ready data stream and fills a 2^ADDR_WIDTH-deep memory at sequential addresses, starting at 0.
- Reports fill count and completion.
- Provides a registered random-access read port so the reader side or the bench can fetch stored words.

---
 rtl/seq_ram_writer_pkg.sv | 13 +
 rtl/sdp_ram.sv | 38 +++
 rtl/seq_ram_writer.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_ram_writer_pkg.sv
// Shared definitions for the sequential RAM writer: FSM state encoding and default widths.
package seq_ram_writer_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered, read-first read port.
module sdp_ram
    import seq_ram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage is never reset so that contents survive a mid-pass reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the array samples the pre-write value, giving read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/seq_ram_writer.sv
// Fills a RAM at sequential addresses from a valid/ready stream and exposes a readback port.
// Optional running XOR checksum output enabled by defining SEQ_RAM_WRITER_CSUM_EN.
module seq_ram_writer
    import seq_ram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_count,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
`ifdef SEQ_RAM_WRITER_CSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] o_csum
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_accept;

    assign w_accept = r_ready && i_valid;

    // Handshake flags are registered alongside the state so no path exists from i_valid to o_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_FILL;
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_ptr   <= r_ptr + PTR_ONE;
                        r_count <= r_count + CNT_ONE;
                        if (r_ptr == PTR_LAST) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_RAM_WRITER_CSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if ((r_state != S_FILL) && i_start) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum ^ i_data;
        end
    end

    assign o_csum = r_csum;
`endif

    sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_ptr),
        .i_wr_data (i_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_count = r_count;

endmodule
